// File: rtl/bram_stream_loader.sv
// Framed byte-stream loader: parses ADDR/LEN/data/CSUM frames from a
// valid/ready byte stream and turns the data bytes into single-cycle BRAM
// write strobes, refusing any write outside the configured address window.
module bram_stream_loader #(
  parameter int unsigned address_width = 16,
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned EndAddress    = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [address_width-1:0] addr,
  output logic                     wr,
  output logic [7:0]               din,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned AW = address_width;

  // Window limits widened to 17 bits so start+N-1 never wraps.
  localparam logic [16:0] BASE17 = 17'(BaseAddress);
  localparam logic [16:0] END17  = 17'(EndAddress);
  localparam logic [16:0] TOP17  = 17'((64'd1 << AW) - 64'd1);

  typedef enum logic [2:0] {
    IDLE,
    A_LO,
    A_HI,
    L_LO,
    L_HI,
    DATA,
    CSUM
  } state_t;

  state_t          state;
  logic [7:0]      lo_byte;
  logic [15:0]     start;
  logic [15:0]     remaining;
  logic [AW-1:0]   ptr;
  logic [7:0]      sum;
  logic            range_err;

  logic            take_c;
  logic [15:0]     word_c;
  logic [16:0]     start17_c;
  logic [16:0]     last17_c;
  logic [17:0]     base_diff_c;
  logic [17:0]     end_diff_c;
  logic [17:0]     top_diff_c;
  logic [17:0]     hi_diff_c;
  logic            hi_bad_c;
  logic            len_bad_c;
  logic [7:0]      sum_next_c;

  // The BRAM takes one write per cycle, so the only flow control is enable.
  assign s_ready = en & ~reset;
  assign take_c  = s_valid & s_ready;

  // Header decode and window checks; comparisons are done via borrow bits.
  always_comb begin
    word_c      = {s_data, lo_byte};
    start17_c   = {1'b0, start};
    last17_c    = start17_c + {1'b0, word_c} - 17'd1;
    hi_diff_c   = {1'b0, TOP17} - {2'b00, word_c};
    hi_bad_c    = hi_diff_c[17];
    base_diff_c = {1'b0, start17_c} - {1'b0, BASE17};
    end_diff_c  = {1'b0, END17} - {1'b0, last17_c};
    top_diff_c  = {1'b0, TOP17} - {1'b0, last17_c};
    len_bad_c   = base_diff_c[17] ||
                  ((word_c != 16'd0) && (end_diff_c[17] || top_diff_c[17]));
    sum_next_c  = sum + s_data;
  end

  // Frame FSM with registered BRAM bus and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lo_byte   <= 8'd0;
      start     <= 16'd0;
      remaining <= 16'd0;
      ptr       <= '0;
      sum       <= 8'd0;
      range_err <= 1'b0;
      addr      <= '0;
      wr        <= 1'b0;
      din       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr    <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      if (take_c) begin
        case (state)
          IDLE, A_LO: begin
            lo_byte   <= s_data;
            sum       <= 8'd0;
            range_err <= 1'b0;
            busy      <= 1'b1;
            state     <= A_HI;
          end
          A_HI: begin
            start <= word_c;
            if (hi_bad_c) range_err <= 1'b1;
            state <= L_LO;
          end
          L_LO: begin
            lo_byte <= s_data;
            state   <= L_HI;
          end
          L_HI: begin
            remaining <= word_c;
            ptr       <= start[AW-1:0];
            if (len_bad_c) range_err <= 1'b1;
            state <= (word_c == 16'd0) ? CSUM : DATA;
          end
          DATA: begin
            sum       <= sum_next_c;
            remaining <= remaining - 16'd1;
            // Out-of-window frames are drained without touching the BRAM.
            if (!range_err) begin
              wr   <= 1'b1;
              addr <= ptr;
              din  <= s_data;
              ptr  <= ptr + AW'(1);
            end
            if (remaining == 16'd1) state <= CSUM;
          end
          CSUM: begin
            if (!range_err && (s_data == sum)) done <= 1'b1;
            else                               error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Bench for bram_stream_loader: two instances with different address windows
// share one stimulus stream; a scoreboard holds expected writes and outcomes.
module tb_bram_stream_loader;

  localparam int unsigned BASE_A = 32'h0000;
  localparam int unsigned END_A  = 32'h00FF;
  localparam int unsigned BASE_B = 32'h0020;
  localparam int unsigned END_B  = 32'h002F;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_exp_t;

  typedef struct {
    logic is_done;
    int   cyc;
  } ev_exp_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready_a, s_ready_b;
  logic [15:0] addr_a, addr_b;
  logic        wr_a, wr_b;
  logic [7:0]  din_a, din_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        error_a, error_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit jitter   = 1'b0;

  wr_exp_t    exp_wr0[$];
  wr_exp_t    exp_wr1[$];
  ev_exp_t    exp_ev0[$];
  ev_exp_t    exp_ev1[$];
  logic [7:0] payload[$];

  bram_stream_loader #(.address_width(16), .BaseAddress(BASE_A), .EndAddress(END_A)) dut_a (
    .clk(clk), .reset(reset), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready_a), .addr(addr_a), .wr(wr_a), .din(din_a),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  bram_stream_loader #(.address_width(16), .BaseAddress(BASE_B), .EndAddress(END_B)) dut_b (
    .clk(clk), .reset(reset), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready_b), .addr(addr_b), .wr(wr_b), .din(din_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Window model: start below base, or last byte past the window / address space.
  function automatic logic model_err(input int d, input int unsigned start, input int unsigned n);
    int unsigned base;
    int unsigned lim;
    int unsigned last;
    base = (d == 0) ? BASE_A : BASE_B;
    lim  = (d == 0) ? END_A  : END_B;
    last = start + n - 1;
    return (start < base) || ((n != 0) && ((last > lim) || (last > 32'hFFFF)));
  endfunction

  // Compare one instance's outputs against the scoreboard.
  task automatic observe(input int d, input logic w, input logic [15:0] a, input logic [7:0] dn,
                         input logic dne, input logic er);
    wr_exp_t we;
    ev_exp_t ev;
    int      qs;
    if (w) begin
      qs = (d == 0) ? exp_wr0.size() : exp_wr1.size();
      check($sformatf("wr_pending%0d", d), 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        we = (d == 0) ? exp_wr0.pop_front() : exp_wr1.pop_front();
        check($sformatf("wr_addr%0d", d), 32'(a), 32'(we.a));
        check($sformatf("wr_din%0d", d), 32'(dn), 32'(we.d));
        check($sformatf("wr_cyc%0d", d), 32'(cyc), 32'(we.cyc));
      end
    end
    if (dne || er) begin
      qs = (d == 0) ? exp_ev0.size() : exp_ev1.size();
      check($sformatf("ev_pending%0d", d), 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        ev = (d == 0) ? exp_ev0.pop_front() : exp_ev1.pop_front();
        check($sformatf("done%0d", d), 32'(dne), 32'(ev.is_done));
        check($sformatf("error%0d", d), 32'(er), 32'(!ev.is_done));
        check($sformatf("ev_cyc%0d", d), 32'(cyc), 32'(ev.cyc));
      end
    end
  endtask

  // Outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    observe(0, wr_a, addr_a, din_a, done_a, error_a);
    observe(1, wr_b, addr_b, din_b, done_b, error_b);
  end

  // Present one byte, optionally with idle gaps and enable stalls; returns #1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int  waits;
    bit  seen;
    if (jitter) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 1) == 1) begin
        s_data  = b;
        s_valid = 1'b1;
        en      = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
        en = 1'b1;
      end
    end
    s_data  = b;
    s_valid = 1'b1;
    waits   = 0;
    seen    = 1'b0;
    while (!seen && waits < 100) begin
      @(posedge clk);
      if (s_ready_a) seen = 1'b1;
      waits++;
    end
    check("handshake", 32'(seen), 32'd1);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("s_ready_in_reset", 32'(s_ready_a), 32'd0);
    @(posedge clk);
    #1;
    check("rst_wr", 32'(wr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;
  endtask

  // Drive one frame using payload[]; abort_after >= 0 resets after that many data bytes.
  task automatic send_frame(input int unsigned start, input int unsigned n,
                            input logic [7:0] csum_delta, input int abort_after);
    logic [7:0] sum;
    logic       err0, err1;
    ev_exp_t    ev;
    wr_exp_t    we;
    err0 = model_err(0, start, n);
    err1 = model_err(1, start, n);
    sum  = 8'd0;
    send_byte(8'(start));
    check("busy_rise", 32'(busy_a), 32'd1);
    send_byte(8'(start >> 8));
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < int'(n); i++) begin
      if (i == abort_after) begin
        do_reset();
        return;
      end
      sum = sum + payload[i];
      send_byte(payload[i]);
      we.a   = 16'(start + i);
      we.d   = payload[i];
      we.cyc = cyc;
      if (!err0) exp_wr0.push_back(we);
      if (!err1) exp_wr1.push_back(we);
    end
    send_byte(sum + csum_delta);
    ev.cyc     = cyc;
    ev.is_done = !err0 && (csum_delta == 8'd0);
    exp_ev0.push_back(ev);
    ev.is_done = !err1 && (csum_delta == 8'd0);
    exp_ev1.push_back(ev);
    check("busy_fall", 32'(busy_a), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("s_ready_reset", 32'(s_ready_a), 32'd0);
    check("addr_reset", 32'(addr_a), 32'd0);
    check("wr_reset", 32'(wr_a), 32'd0);
    check("din_reset", 32'(din_a), 32'd0);
    check("busy_reset", 32'(busy_a), 32'd0);
    check("done_reset", 32'(done_a), 32'd0);
    check("error_reset", 32'(error_a), 32'd0);
    reset = 1'b0;
    #1;
    check("s_ready_en", 32'(s_ready_a), 32'd1);
    en = 1'b0;
    #1;
    check("s_ready_dis", 32'(s_ready_a), 32'd0);
    en = 1'b1;
    @(posedge clk);
    #1;

    // Good frame followed back-to-back by the same frame with a bad checksum.
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(32'h0010, 3, 8'h00, -1);
    send_frame(32'h0010, 3, 8'h01, -1);

    // Frame straddling the top of instance b's window.
    payload = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(32'h002E, 4, 8'h00, -1);

    // Empty frame.
    payload = {};
    send_frame(32'h0000, 0, 8'h00, -1);

    // Gappy stream with enable stalls.
    jitter  = 1'b1;
    payload = {};
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
    send_frame(32'h0020, 8, 8'h00, -1);
    jitter = 1'b0;

    // Reset after two data bytes, then a fresh frame.
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(32'h0028, 5, 8'h00, 2);
    payload = '{8'h5A, 8'hC3};
    send_frame(32'h0030, 2, 8'h00, -1);

    // Frame running past the top of the address space.
    payload = '{8'h77, 8'h88};
    send_frame(32'hFFFF, 2, 8'h00, -1);

    repeat (5) @(posedge clk);
    #1;
    check("wr_left0", 32'(exp_wr0.size()), 32'd0);
    check("wr_left1", 32'(exp_wr1.size()), 32'd0);
    check("ev_left0", 32'(exp_ev0.size()), 32'd0);
    check("ev_left1", 32'(exp_ev1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
